// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the EX stage.
// Single-cycle ops return a registered result one clock after accept.
// MULT/MULTU run shift-add and DIV/DIVU run restoring division, one bit per clock.
// Both return a 2*DATA_WIDTH result as rslt_hi_87/rslt_87.
module alu_mc #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_87,
  input  logic                  rst_n_87,
  input  logic                  start_87,
  input  logic                  flush_87,
  input  logic [3:0]            alu_op_87,
  input  logic [DATA_WIDTH-1:0] arg_a_87,
  input  logic [DATA_WIDTH-1:0] arg_b_87,
  output logic                  ready_87,
  output logic                  busy_87,
  output logic                  done_87,
  output logic [DATA_WIDTH-1:0] rslt_87,
  output logic [DATA_WIDTH-1:0] rslt_hi_87,
  output logic                  zero_87,
  output logic                  overflow_87,
  output logic                  div_zero_87,
  output logic                  invalid_op_87
);

  localparam int W = DATA_WIDTH;

  // Op-code encoding shared with the combinational ALU; 14 and 15 are unused.
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_ADDU  = 4'd1;
  localparam logic [3:0] ALU_SUB   = 4'd2;
  localparam logic [3:0] ALU_SUBU  = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_MULT  = 4'd10;
  localparam logic [3:0] ALU_MULTU = 4'd11;
  localparam logic [3:0] ALU_DIV   = 4'd12;
  localparam logic [3:0] ALU_DIVU  = 4'd13;

  localparam logic [SHAMT_WIDTH-1:0] CNT_INIT = SHAMT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, next_state;

  logic                   accept;
  logic                   in_multi, in_div, in_signed;
  logic [W-1:0]           a_mag, b_mag, add_sum, sub_diff;
  logic [W-1:0]           sc_lo;
  logic                   sc_ovf, sc_inv;

  logic [W-1:0]           a_raw_q, b_q, acc_q, lo_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic                   is_div_q, neg_q, rem_neg_q;

  logic [W:0]             mul_sum, div_shift, div_diff;
  logic                   div_ok;
  logic [W-1:0]           acc_nx, lo_nx;
  logic [2*W-1:0]         prod, prod_fix;
  logic [W-1:0]           fix_lo, fix_hi;
  logic                   fix_dz;

  assign busy_87  = (state == CALC) || (state == FIX);
  assign ready_87 = ~busy_87;
  assign done_87  = (state == DONE);
  assign accept   = start_87 & ready_87 & ~flush_87;

  assign in_multi  = (alu_op_87 == ALU_MULT) || (alu_op_87 == ALU_MULTU) ||
                     (alu_op_87 == ALU_DIV)  || (alu_op_87 == ALU_DIVU);
  assign in_div    = (alu_op_87 == ALU_DIV)  || (alu_op_87 == ALU_DIVU);
  assign in_signed = (alu_op_87 == ALU_MULT) || (alu_op_87 == ALU_DIV);

  assign a_mag    = (in_signed && arg_a_87[W-1]) ? -arg_a_87 : arg_a_87;
  assign b_mag    = (in_signed && arg_b_87[W-1]) ? -arg_b_87 : arg_b_87;
  assign add_sum  = arg_a_87 + arg_b_87;
  assign sub_diff = arg_a_87 - arg_b_87;

  // Result and flags of the single-cycle ops, computed from the live inputs at accept.
  always_comb begin
    sc_lo  = '0;
    sc_ovf = 1'b0;
    sc_inv = 1'b0;
    case (alu_op_87)
      ALU_ADD: begin
        sc_lo  = add_sum;
        sc_ovf = (arg_a_87[W-1] == arg_b_87[W-1]) && (add_sum[W-1] != arg_a_87[W-1]);
      end
      ALU_ADDU: sc_lo = add_sum;
      ALU_SUB: begin
        sc_lo  = sub_diff;
        sc_ovf = (arg_a_87[W-1] != arg_b_87[W-1]) && (sub_diff[W-1] != arg_a_87[W-1]);
      end
      ALU_SUBU: sc_lo = sub_diff;
      ALU_AND:  sc_lo = arg_a_87 & arg_b_87;
      ALU_OR:   sc_lo = arg_a_87 | arg_b_87;
      ALU_SLT:  sc_lo = {{(W-1){1'b0}}, ($signed(arg_a_87) < $signed(arg_b_87))};
      ALU_SLTU: sc_lo = {{(W-1){1'b0}}, (arg_a_87 < arg_b_87)};
      ALU_SLL:  sc_lo = arg_a_87 << arg_b_87[SHAMT_WIDTH-1:0];
      ALU_SRL:  sc_lo = arg_a_87 >> arg_b_87[SHAMT_WIDTH-1:0];
      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: sc_lo = '0;
      default:  sc_inv = 1'b1;
    endcase
  end

  // One iteration step: shift-add for multiply, restore-or-keep for divide.
  always_comb begin
    mul_sum   = lo_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
    div_shift = {acc_q, lo_q[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = ~div_diff[W];
    if (is_div_q) begin
      acc_nx = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
      lo_nx  = {lo_q[W-2:0], div_ok};
    end else begin
      acc_nx = mul_sum[W:1];
      lo_nx  = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  // Sign restoration and divide-by-zero substitution applied in FIX.
  always_comb begin
    prod     = {acc_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    fix_dz   = 1'b0;
    if (!is_div_q) begin
      fix_lo = prod_fix[W-1:0];
      fix_hi = prod_fix[2*W-1:W];
    end else if (b_q == '0) begin
      fix_lo = '1;
      fix_hi = a_raw_q;
      fix_dz = 1'b1;
    end else begin
      fix_lo = neg_q ? -lo_q : lo_q;
      fix_hi = rem_neg_q ? -acc_q : acc_q;
    end
  end

  // State register.
  always_ff @(posedge clk_87 or negedge rst_n_87) begin
    if (!rst_n_87) state <= IDLE;
    else           state <= next_state;
  end

  // Next-state logic; flush wins over start and aborts CALC/FIX.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = in_multi ? CALC : DONE;
      CALC: begin
        if (flush_87)           next_state = IDLE;
        else if (cnt_q == '0)   next_state = FIX;
      end
      FIX:  next_state = flush_87 ? IDLE : DONE;
      DONE: begin
        if (accept) next_state = in_multi ? CALC : DONE;
        else        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, iteration registers and the held result/flag outputs.
  always_ff @(posedge clk_87 or negedge rst_n_87) begin
    if (!rst_n_87) begin
      a_raw_q       <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      lo_q          <= '0;
      cnt_q         <= '0;
      is_div_q      <= 1'b0;
      neg_q         <= 1'b0;
      rem_neg_q     <= 1'b0;
      rslt_87       <= '0;
      rslt_hi_87    <= '0;
      zero_87       <= 1'b0;
      overflow_87   <= 1'b0;
      div_zero_87   <= 1'b0;
      invalid_op_87 <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (in_multi) begin
              a_raw_q   <= arg_a_87;
              b_q       <= b_mag;
              lo_q      <= a_mag;
              acc_q     <= '0;
              cnt_q     <= CNT_INIT;
              is_div_q  <= in_div;
              neg_q     <= in_signed & (arg_a_87[W-1] ^ arg_b_87[W-1]);
              rem_neg_q <= in_signed & arg_a_87[W-1];
            end else begin
              rslt_87       <= sc_lo;
              rslt_hi_87    <= '0;
              zero_87       <= (sc_lo == '0) && !sc_inv;
              overflow_87   <= sc_ovf;
              div_zero_87   <= 1'b0;
              invalid_op_87 <= sc_inv;
            end
          end
        end
        CALC: begin
          if (!flush_87) begin
            acc_q <= acc_nx;
            lo_q  <= lo_nx;
            cnt_q <= cnt_q - SHAMT_WIDTH'(1);
          end
        end
        FIX: begin
          if (!flush_87) begin
            rslt_87       <= fix_lo;
            rslt_hi_87    <= fix_hi;
            zero_87       <= (fix_lo == '0);
            overflow_87   <= 1'b0;
            div_zero_87   <= fix_dz;
            invalid_op_87 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 32;

  localparam logic [3:0] ADD = 4'd0,  ADDU = 4'd1,  SUB = 4'd2,  SUBU = 4'd3;
  localparam logic [3:0] AND_ = 4'd4, OR_ = 4'd5,   SLT = 4'd6,  SLTU = 4'd7;
  localparam logic [3:0] SLL = 4'd8,  SRL = 4'd9,   MULT = 4'd10, MULTU = 4'd11;
  localparam logic [3:0] DIV = 4'd12, DIVU = 4'd13;

  logic         clk_87 = 1'b0;
  logic         rst_n_87 = 1'b0;
  logic         start_87 = 1'b0;
  logic         flush_87 = 1'b0;
  logic [3:0]   alu_op_87 = '0;
  logic [W-1:0] arg_a_87 = '0;
  logic [W-1:0] arg_b_87 = '0;
  logic         ready_87, busy_87, done_87;
  logic [W-1:0] rslt_87, rslt_hi_87;
  logic         zero_87, overflow_87, div_zero_87, invalid_op_87;

  int tests = 0;
  int failures = 0;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clk_87(clk_87), .rst_n_87(rst_n_87), .start_87(start_87), .flush_87(flush_87),
    .alu_op_87(alu_op_87), .arg_a_87(arg_a_87), .arg_b_87(arg_b_87),
    .ready_87(ready_87), .busy_87(busy_87), .done_87(done_87),
    .rslt_87(rslt_87), .rslt_hi_87(rslt_hi_87), .zero_87(zero_87),
    .overflow_87(overflow_87), .div_zero_87(div_zero_87), .invalid_op_87(invalid_op_87)
  );

  always #5 clk_87 = ~clk_87;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the arithmetic rules of each op.
  task automatic refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] lo, output logic [W-1:0] hi,
                          output logic z, output logic ov, output logic dz, output logic inv,
                          output int lat);
    longint sa, sb, s, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = '0; hi = '0; ov = 1'b0; dz = 1'b0; inv = 1'b0; lat = 1;
    case (op)
      ADD:   begin s = sa + sb; lo = s[31:0]; ov = (s != longint'($signed(lo))); end
      ADDU:  lo = a + b;
      SUB:   begin s = sa - sb; lo = s[31:0]; ov = (s != longint'($signed(lo))); end
      SUBU:  lo = a - b;
      AND_:  lo = a & b;
      OR_:   lo = a | b;
      SLT:   lo = (sa < sb) ? 32'd1 : 32'd0;
      SLTU:  lo = (a < b) ? 32'd1 : 32'd0;
      SLL:   lo = a << b[4:0];
      SRL:   lo = a >> b[4:0];
      MULT:  begin p = sa * sb; lo = p[31:0]; hi = p[63:32]; lat = W + 2; end
      MULTU: begin p = {32'b0, a} * {32'b0, b}; lo = p[31:0]; hi = p[63:32]; lat = W + 2; end
      DIV, DIVU: begin
        lat = W + 2;
        if (b == '0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else if (op == DIV) begin
          q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      default: inv = 1'b1;
    endcase
    z = (lo == '0) && !inv;
  endtask

  // Presents one request at a falling edge and withdraws it just after the accepting edge.
  task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int g = 0;
    @(negedge clk_87);
    while (!ready_87 && g < 100) begin
      @(negedge clk_87);
      g++;
    end
    if (g == 100) checkOutput("ready_wait", 64'(ready_87), 64'd1);
    alu_op_87 = op; arg_a_87 = a; arg_b_87 = b; start_87 = 1'b1;
    @(posedge clk_87);
    #1 start_87 = 1'b0;
  endtask

  // Counts falling edges until done_87 (bounded) and how many of them saw busy_87.
  task automatic waitDone(output int n, output int nbusy);
    n = 0; nbusy = 0;
    do begin
      @(negedge clk_87);
      n++;
      if (busy_87) nbusy++;
    end while (!done_87 && n < 200);
  endtask

  // Runs one op end to end and compares every output against the model.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] elo, ehi;
    logic ez, eo, ed, ei;
    int lat, n, nb;
    refModel(op, a, b, elo, ehi, ez, eo, ed, ei, lat);
    launch(op, a, b);
    waitDone(n, nb);
    checkOutput($sformatf("latency op%0d", op), 64'(n), 64'(lat));
    checkOutput($sformatf("busy op%0d", op), 64'(nb), 64'(lat - 1));
    checkOutput($sformatf("rslt op%0d a=%h b=%h", op, a, b), 64'(rslt_87), 64'(elo));
    checkOutput($sformatf("rslt_hi op%0d a=%h b=%h", op, a, b), 64'(rslt_hi_87), 64'(ehi));
    checkOutput($sformatf("flags op%0d", op),
                64'({zero_87, overflow_87, div_zero_87, invalid_op_87}), 64'({ez, eo, ed, ei}));
  endtask

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int n, nb, cnt, total;
    $display("[TB] alu_mc test start");

    #12;
    checkOutput("reset ready", 64'(ready_87), 64'd1);
    checkOutput("reset outputs", 64'({busy_87, done_87, zero_87, overflow_87, div_zero_87, invalid_op_87}), 64'd0);
    checkOutput("reset rslt", 64'({rslt_hi_87, rslt_87}), 64'd0);
    @(negedge clk_87);
    rst_n_87 = 1'b1;

    applyStimulus(ADD, 32'd5, 32'd7);
    applyStimulus(SUB, 32'd7, 32'd7);
    applyStimulus(ADD, 32'h7FFF_FFFF, 32'd1);
    applyStimulus(ADDU, 32'h7FFF_FFFF, 32'd1);
    applyStimulus(SLT, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(SLTU, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(SLL, 32'd1, 32'h23);
    applyStimulus(MULT, -32'sd3, 32'd5);
    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'd2);
    applyStimulus(DIVU, 32'd100, 32'd7);
    applyStimulus(DIV, -32'sd7, 32'd2);
    applyStimulus(DIV, 32'd9, 32'd0);
    applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(4'd14, 32'd3, 32'd4);

    // A start during MULT is ignored and operand changes do not disturb it.
    launch(MULT, -32'sd3, 32'd5);
    repeat (4) @(negedge clk_87);
    alu_op_87 = ADD; arg_a_87 = 32'd1; arg_b_87 = 32'd1; start_87 = 1'b1;
    @(negedge clk_87);
    start_87 = 1'b0; arg_a_87 = 32'($urandom); arg_b_87 = 32'($urandom);
    waitDone(n, nb);
    checkOutput("ignored start latency", 64'(n + 5), 64'(W + 2));
    checkOutput("ignored start rslt", 64'({rslt_hi_87, rslt_87}), 64'hFFFF_FFFF_FFFF_FFF1);

    // Flush in CALC: no done, ready next clock, earlier result kept.
    applyStimulus(ADD, 32'd5, 32'd7);
    launch(MULTU, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk_87);
    flush_87 = 1'b1;
    @(posedge clk_87);
    #1 flush_87 = 1'b0;
    checkOutput("flush ready", 64'({ready_87, busy_87}), 64'b10);
    cnt = 0;
    repeat (40) begin
      @(negedge clk_87);
      if (done_87) cnt++;
    end
    checkOutput("flush no done", 64'(cnt), 64'd0);
    checkOutput("flush rslt kept", 64'({rslt_hi_87, rslt_87}), 64'd12);

    // Back-to-back start in the DONE cycle.
    launch(ADD, 32'd1, 32'd2);
    waitDone(n, nb);
    alu_op_87 = ADD; arg_a_87 = 32'd10; arg_b_87 = 32'd20; start_87 = 1'b1;
    @(posedge clk_87);
    #1 start_87 = 1'b0;
    @(negedge clk_87);
    checkOutput("b2b done", 64'(done_87), 64'd1);
    checkOutput("b2b rslt", 64'(rslt_87), 64'd30);

    // Flush in DONE blocks a same-cycle start.
    alu_op_87 = ADD; arg_a_87 = 32'd100; arg_b_87 = 32'd1; start_87 = 1'b1; flush_87 = 1'b1;
    @(posedge clk_87);
    #1 start_87 = 1'b0; flush_87 = 1'b0;
    @(negedge clk_87);
    checkOutput("flush done no accept", 64'({done_87, ready_87}), 64'b01);
    checkOutput("flush done rslt", 64'(rslt_87), 64'd30);

    // Asynchronous reset in the middle of a divide.
    launch(DIV, 32'd100, 32'd7);
    repeat (10) @(negedge clk_87);
    #2 rst_n_87 = 1'b0;
    #1;
    checkOutput("midreset ready", 64'({ready_87, busy_87, done_87}), 64'b100);
    checkOutput("midreset rslt", 64'({rslt_hi_87, rslt_87}), 64'd0);
    checkOutput("midreset flags", 64'({zero_87, overflow_87, div_zero_87, invalid_op_87}), 64'd0);
    @(negedge clk_87);
    rst_n_87 = 1'b1;
    applyStimulus(ADD, 32'd5, 32'd7);

    // Randomized ops against the model.
    total = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), randOperand(), randOperand());
      total++;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
